// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank: register addresses, STATUS
// bit positions, command-byte field positions and the command FSM states.
// Optional build macro SPI_REG_BANK_CMDCOUNT_EN is consumed by spi_reg_bank.
package spi_reg_pkg;

  localparam logic [2:0] REG_ID     = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LAST   = 3'd7;

  localparam int STATUS_TIMEOUT_BIT = 0;
  localparam int STATUS_PENDING_BIT = 1;

  localparam int CMD_W_BIT    = 7;
  localparam int CMD_ADDR_MSB = 2;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  // Assemble the STATUS register image; unused bits read 0.
  function automatic logic [7:0] status_byte(input logic pending, input logic timeout);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_PENDING_BIT] = pending;
    s[STATUS_TIMEOUT_BIT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/spi_reg_timeout.sv
// Watchdog for the write handshake: a loadable down-counter.
// i_load presets the count to TIMEOUT_CYCLES-1; each cycle with i_en set
// counts down, and o_expire is asserted (combinationally) in the enabled
// cycle where the count has already reached zero. That makes the expiry
// land on the TIMEOUT_CYCLES-th enabled cycle after a load.
// Ports: clk, rst_n (async active-low), i_load, i_en, o_expire.
module spi_reg_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VALUE = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE        = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VALUE;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/spi_reg_bank.sv
// Command consumer behind a byte-level SPI slave. Each command byte is
// decoded as a read (response <= register) or as the first half of a write
// (response <= ACK_BYTE, next byte is the data). Data writes pulse
// wr_strobe for the target register and echo the stored value.
// Ports: clk, rst_n (async active-low), cmd[7:0], cmd_valid,
//        response[7:0] (registered), reg_out[63:0] (reg N at [8N+7:8N]),
//        wr_strobe[7:0].
// Build macro SPI_REG_BANK_CMDCOUNT_EN: reg 7 becomes a read-only count of
// cmd_valid pulses instead of an ordinary read/write register.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter logic [7:0]  ID_VALUE       = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd,
  input  logic        cmd_valid,
  output logic [7:0]  response,
  output logic [63:0] reg_out,
  output logic [7:0]  wr_strobe
);

`ifdef SPI_REG_BANK_CMDCOUNT_EN
  localparam int RW_LAST = 6;
`else
  localparam int RW_LAST = 7;
`endif

  state_t      r_state;
  logic [2:0]  r_addr;
  logic [7:0]  r_response;
  logic [7:0]  r_strobe;
  logic        r_timeout;
  logic [7:0]  r_regs [2:RW_LAST];
`ifdef SPI_REG_BANK_CMDCOUNT_EN
  logic [7:0]  r_cnt;
`endif

  logic [2:0]  w_cmd_addr;
  logic        w_load;
  logic        w_en;
  logic        w_expire;
  logic        w_timeout_next;
  logic [7:0]  w_rd_data;
  logic [7:0]  w_echo;
  logic [63:0] w_reg_out;

  assign w_cmd_addr = cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign w_load     = (r_state == IDLE) && cmd_valid && cmd[CMD_W_BIT];
  // A data byte arriving on the expiry cycle must win, so the watchdog
  // only runs in cycles without cmd_valid.
  assign w_en       = (r_state == WAIT_DATA) && !cmd_valid;
  // STATUS.TIMEOUT is write-one-to-clear.
  assign w_timeout_next = r_timeout & ~cmd[STATUS_TIMEOUT_BIT];

  spi_reg_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  // Read data for a read command (only used in IDLE, so PENDING reads 0).
  always_comb begin
    w_rd_data = 8'h00;
    case (w_cmd_addr)
      REG_ID:     w_rd_data = ID_VALUE;
      REG_STATUS: w_rd_data = status_byte(r_state == WAIT_DATA, r_timeout);
`ifdef SPI_REG_BANK_CMDCOUNT_EN
      REG_LAST:   w_rd_data = r_cnt;
`endif
      default:    w_rd_data = r_regs[w_cmd_addr];
    endcase
  end

  // Value stored after the data byte lands; echoed back as the response.
  always_comb begin
    w_echo = cmd;
    case (r_addr)
      REG_ID:     w_echo = ID_VALUE;
      REG_STATUS: w_echo = status_byte(1'b0, w_timeout_next);
`ifdef SPI_REG_BANK_CMDCOUNT_EN
      REG_LAST:   w_echo = r_cnt + 8'd1;
`endif
      default:    w_echo = cmd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= 3'd0;
      r_response <= 8'h00;
      r_strobe   <= 8'h00;
      r_timeout  <= 1'b0;
      for (int i = 2; i <= RW_LAST; i++) r_regs[i] <= 8'h00;
    end else begin
      r_strobe <= 8'h00;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd[CMD_W_BIT]) begin
              r_addr     <= w_cmd_addr;
              r_response <= ACK_BYTE;
              r_state    <= WAIT_DATA;
            end else begin
              r_response <= w_rd_data;
            end
          end
        end
        WAIT_DATA: begin
          if (cmd_valid) begin
            r_strobe[r_addr] <= 1'b1;
            r_response       <= w_echo;
            r_state          <= IDLE;
            case (r_addr)
              REG_ID:     ;
              REG_STATUS: r_timeout <= w_timeout_next;
`ifdef SPI_REG_BANK_CMDCOUNT_EN
              REG_LAST:   ;
`endif
              default:    r_regs[r_addr] <= cmd;
            endcase
          end else if (w_expire) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_REG_BANK_CMDCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else if (cmd_valid) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`endif

  // ID is a constant rather than fabric state, so its slot is driven 0.
  always_comb begin
    w_reg_out          = 64'h0;
    w_reg_out[15:8]    = status_byte(r_state == WAIT_DATA, r_timeout);
    for (int i = 2; i <= RW_LAST; i++) w_reg_out[8*i +: 8] = r_regs[i];
`ifdef SPI_REG_BANK_CMDCOUNT_EN
    w_reg_out[63:56]   = r_cnt;
`endif
  end

  assign response  = r_response;
  assign wr_strobe = r_strobe;
  assign reg_out   = w_reg_out;

endmodule
